reg_file_sb: RTL

//  Parametrised register file with NUM_RD read ports and one write-back port.

---
 rtl/reg_file_pkg.sv | 14 +
 rtl/reg_file_init_seq.sv | 48 ++++
 rtl/reg_file_sb.sv | 110 +++++++++++
 3 files changed

// File: rtl/reg_file_pkg.sv
// Shared definitions for the scoreboarded register file: sequencer state encoding
// and the register count derived from the address width.
package reg_file_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } seq_state_t;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/reg_file_init_seq.sv
// Post-reset init sequencer: walks every register address once, then hands the
// array over to normal write-back traffic and raises init_done.
module reg_file_init_seq
  import reg_file_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic              init_we,
  output logic [ADDR_W-1:0] init_addr,
  output logic              init_done
);

  seq_state_t        state;
  logic [ADDR_W-1:0] cnt;

  // The last address is written on the same edge that moves us to RUN,
  // so init_done and init_we flip together with the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= INIT;
      cnt       <= '0;
      init_we   <= 1'b1;
      init_done <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == '1) begin
            state     <= RUN;
            init_we   <= 1'b0;
            init_done <= 1'b1;
          end
        end
        RUN: begin
          cnt <= cnt;
        end
        default: begin
          state <= INIT;
        end
      endcase
    end
  end

  assign init_addr = cnt;

endmodule

// File: rtl/reg_file_sb.sv
// Multi-read-port register file with write-to-read bypass and a per-register
// pending scoreboard (set by claim at issue, cleared by write-back).
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 4,
  parameter int NUM_RD    = 2,
  parameter int INIT_MODE = 1,
  parameter int BYPASS    = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     claim_en,
  input  logic [ADDR_W-1:0]        claim_addr,
  output logic                     init_done
);

  localparam int DEPTH = depth_of(ADDR_W);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pending;
  logic              init_we;
  logic [ADDR_W-1:0] init_addr;
  logic [DATA_W-1:0] init_value;
  logic              run;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  reg_file_init_seq #(
    .ADDR_W (ADDR_W)
  ) u_init_seq (
    .clk       (clk),
    .rst       (rst),
    .init_we   (init_we),
    .init_addr (init_addr),
    .init_done (init_done)
  );

  assign run        = init_done;
  assign init_value = (INIT_MODE != 0) ? DATA_W'(init_addr) : '0;

  // The sequencer owns the write port until init completes; write-back is ignored meanwhile.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    if (init_we) begin
      mem_we    = 1'b1;
      mem_waddr = init_addr;
      mem_wdata = init_value;
    end else if (wr_en) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Claim is applied after the write-back clear so a new producer wins a same-address collision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= '0;
    end else if (run) begin
      if (wr_en) begin
        pending[wr_addr] <= 1'b0;
      end
      if (claim_en) begin
        pending[claim_addr] <= 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              busy;
    logic              hit;

    assign addr = rd_addr[k*ADDR_W +: ADDR_W];
    assign hit  = (BYPASS != 0) && wr_en && (wr_addr == addr);

    always_comb begin
      data = '0;
      busy = 1'b0;
      if (run) begin
        if (hit) begin
          data = wr_data;
        end else begin
          data = mem[addr];
          busy = pending[addr];
        end
      end
    end

    assign rd_data[k*DATA_W +: DATA_W] = data;
    assign rd_busy[k]                  = busy;
  end

endmodule
